stopwatch_control: RTL and testbench

- Front-end control stage that sits directly upstream of the stopwatch datapath (counter, BCD conversion, display).
- Takes the raw, bouncy start/stop and clear pushbuttons from the board. It synchronises, debounces and edge-detects them, then runs a run/pause/idle state machine.
- Drives the datapath `stop` level and a one-cycle `clear` pulse. The top level ORs `clear` with system `reset` to zero the counter.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/button_debouncer.sv | 48 ++++
 rtl/stopwatch_control.sv | 95 +++++++++
 tb/tb_stopwatch_control.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-end control stage:
// FSM state encoding and the default debounce interval.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      PAUSED  = 2'b10
   } sw_state_t;

   // 10 ms at 100 MHz
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, hold-time debounce counter and one-cycle press pulse
// for a single raw pushbutton.
module button_debouncer
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level_prev;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         level      <= 1'b0;
         level_prev <= 1'b0;
         press      <= 1'b0;
         count      <= '0;
      end else begin
         sync_1     <= btn;
         sync_2     <= sync_1;
         level_prev <= level;
         press      <= level & ~level_prev;
         // Any cycle of agreement restarts the hold interval, so glitches never leak through.
         if (sync_2 == level) begin
            count <= '0;
         end else if (count == CNT_MAX) begin
            level <= sync_2;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_control.sv
// Run/pause/idle control for the stopwatch datapath: debounces the two buttons
// and drives the stop level and a one-cycle clear pulse.
module stopwatch_control
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   output logic       stop,
   output logic       clear,
   output logic       running,
   output logic [1:0] state
);

   sw_state_t state_q;
   logic      ss_press;
   logic      clr_press;
   logic      unused_ss_level;
   logic      unused_clr_level;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ss_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_start_stop),
      .level (unused_ss_level),
      .press (ss_press)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_clr_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_clear),
      .level (unused_clr_level),
      .press (clr_press)
   );

   assign state = state_q;

   // stop/running are registered alongside state so they change on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         stop    <= 1'b1;
         clear   <= 1'b0;
         running <= 1'b0;
      end else begin
         clear <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clr_press) begin
                  clear <= 1'b1;
               end else if (ss_press) begin
                  state_q <= RUNNING;
                  stop    <= 1'b0;
                  running <= 1'b1;
               end
            end
            RUNNING: begin
               // Clear is deliberately ignored while the count is advancing.
               if (ss_press) begin
                  state_q <= PAUSED;
                  stop    <= 1'b1;
                  running <= 1'b0;
               end
            end
            PAUSED: begin
               if (clr_press) begin
                  state_q <= IDLE;
                  clear   <= 1'b1;
               end else if (ss_press) begin
                  state_q <= RUNNING;
                  stop    <= 1'b0;
                  running <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               stop    <= 1'b1;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control with a short debounce interval; directed scenarios
// plus random button activity compared against a rule-level reference model.
module tb_stopwatch_control;

   localparam int D = 4;
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_PAU  = 2'b10;

   logic       clk;
   logic       reset;
   logic       btn_start_stop;
   logic       btn_clear;
   logic       stop;
   logic       clear;
   logic       running;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   // observations gathered by press()
   int         clear_cnt;
   logic [1:0] clear_state;

   stopwatch_control #(.DEBOUNCE_CYCLES(D)) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_start_stop (btn_start_stop),
      .btn_clear      (btn_clear),
      .stop           (stop),
      .clear          (clear),
      .running        (running),
      .state          (state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A level is accepted once the raw samples taken D+1..2 edges ago all show the
   // new value; the pulse follows one edge later and the FSM reacts one edge after that.
   logic [D:0] m_hist_ss, m_hist_clr;
   logic       m_stable_ss, m_stable_clr;
   logic       m_rose_ss, m_rose_clr;
   logic       m_press_ss, m_press_clr;
   logic [1:0] m_state;
   logic       m_clear;

   always @(posedge clk) begin
      logic new_ss, new_clr;
      if (reset) begin
         m_hist_ss = '0;  m_hist_clr = '0;
         m_stable_ss = 0; m_stable_clr = 0;
         m_rose_ss = 0;   m_rose_clr = 0;
         m_press_ss = 0;  m_press_clr = 0;
         m_state = S_IDLE;
         m_clear = 0;
      end else begin
         m_clear = 0;
         if (m_state == S_RUN) begin
            if (m_press_ss) m_state = S_PAU;
         end else if (m_press_clr) begin
            m_state = S_IDLE;
            m_clear = 1;
         end else if (m_press_ss) begin
            m_state = S_RUN;
         end
         m_press_ss  = m_rose_ss;
         m_press_clr = m_rose_clr;
         new_ss  = (m_hist_ss[D:1]  == {D{~m_stable_ss}})  ? ~m_stable_ss  : m_stable_ss;
         new_clr = (m_hist_clr[D:1] == {D{~m_stable_clr}}) ? ~m_stable_clr : m_stable_clr;
         m_rose_ss    = new_ss & ~m_stable_ss;
         m_rose_clr   = new_clr & ~m_stable_clr;
         m_stable_ss  = new_ss;
         m_stable_clr = new_clr;
         m_hist_ss  = {m_hist_ss[D-1:0], btn_start_stop};
         m_hist_clr = {m_hist_clr[D-1:0], btn_clear};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic ss, input logic clr);
      btn_start_stop = ss;
      btn_clear      = clr;
      @(negedge clk);
   endtask

   // Clean press then debounced release; records clear pulses seen.
   task automatic press(input logic ss, input logic clr);
      clear_cnt   = 0;
      clear_state = 2'bxx;
      for (int i = 0; i < D + 3; i++) begin
         step(ss, clr);
         if (clear) begin clear_cnt++; clear_state = state; end
      end
      for (int i = 0; i < D + 4; i++) begin
         step(1'b0, 1'b0);
         if (clear) begin clear_cnt++; clear_state = state; end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %b want %b", state, S_IDLE); end
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL reset_stop got %b want 1", stop); end
      checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", clear); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
      reset = 1'b0;
   endtask

   task automatic test_bounce;
      for (int j = 0; j < 20; j++) begin
         step((j < 8) ? ((j % 2) == 0) : 1'b0, 1'b0);
         checks++;
         if (state !== S_IDLE || stop !== 1'b1 || clear !== 1'b0) begin
            errors++;
            $display("FAIL bounce cyc %0d state %b stop %b clear %b want IDLE/1/0", j, state, stop, clear);
         end
      end
   endtask

   task automatic test_hold_start;
      logic [1:0] exp_s;
      for (int j = 0; j < 20; j++) begin
         step(1'b1, 1'b0);
         exp_s = (j >= D + 3) ? S_RUN : S_IDLE;
         checks++;
         if (state !== exp_s || stop !== (exp_s != S_RUN) || running !== (exp_s == S_RUN)) begin
            errors++;
            $display("FAIL hold_start cyc %0d state %b stop %b running %b want state %b", j, state, stop, running, exp_s);
         end
      end
      for (int j = 0; j < D + 4; j++) step(1'b0, 1'b0);
      checks++; if (state !== S_RUN) begin errors++; $display("FAIL hold_release state %b want %b", state, S_RUN); end
   endtask

   task automatic test_run_pause_clear;
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      checks++; if (state !== S_IDLE) begin errors++; $display("FAIL setup_idle state %b want %b", state, S_IDLE); end
      press(1'b1, 1'b0);
      checks++; if (state !== S_RUN || stop !== 1'b0 || clear_cnt != 0) begin errors++; $display("FAIL rpc_run state %b stop %b clears %0d want 01/0/0", state, stop, clear_cnt); end
      press(1'b1, 1'b0);
      checks++; if (state !== S_PAU || stop !== 1'b1 || clear_cnt != 0) begin errors++; $display("FAIL rpc_pause state %b stop %b clears %0d want 10/1/0", state, stop, clear_cnt); end
      press(1'b0, 1'b1);
      checks++; if (state !== S_IDLE || stop !== 1'b1) begin errors++; $display("FAIL rpc_idle state %b stop %b want 00/1", state, stop); end
      checks++; if (clear_cnt != 1 || clear_state !== S_IDLE) begin errors++; $display("FAIL rpc_clear_pulse count %0d state %b want 1/00", clear_cnt, clear_state); end
   endtask

   task automatic test_clear_running;
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      checks++; if (state !== S_RUN || stop !== 1'b0 || clear_cnt != 0) begin errors++; $display("FAIL clr_in_run state %b stop %b clears %0d want 01/0/0", state, stop, clear_cnt); end
   endtask

   task automatic test_simultaneous;
      press(1'b1, 1'b1);
      checks++; if (state !== S_PAU || clear_cnt != 0) begin errors++; $display("FAIL simul_run state %b clears %0d want 10/0", state, clear_cnt); end
      press(1'b1, 1'b1);
      checks++; if (state !== S_IDLE || clear_cnt != 1) begin errors++; $display("FAIL simul_pause state %b clears %0d want 00/1", state, clear_cnt); end
      press(1'b1, 1'b1);
      checks++; if (state !== S_IDLE || clear_cnt != 1) begin errors++; $display("FAIL simul_idle state %b clears %0d want 00/1", state, clear_cnt); end
   endtask

   task automatic test_reset_mid_debounce;
      logic [1:0] exp_s;
      press(1'b1, 1'b0);
      checks++; if (state !== S_RUN) begin errors++; $display("FAIL rmd_setup state %b want %b", state, S_RUN); end
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      reset = 1'b1;
      step(1'b1, 1'b0);
      reset = 1'b0;
      checks++;
      if (state !== S_IDLE || stop !== 1'b1 || clear !== 1'b0 || running !== 1'b0) begin
         errors++;
         $display("FAIL rmd_reset state %b stop %b clear %b running %b want 00/1/0/0", state, stop, clear, running);
      end
      for (int j = 0; j < 14; j++) begin
         step(1'b1, 1'b0);
         exp_s = (j >= D + 3) ? S_RUN : S_IDLE;
         checks++;
         if (state !== exp_s || stop !== (exp_s != S_RUN)) begin
            errors++;
            $display("FAIL rmd_rerun cyc %0d state %b stop %b want state %b", j, state, stop, exp_s);
         end
      end
      for (int j = 0; j < D + 4; j++) step(1'b0, 1'b0);
   endtask

   task automatic test_random;
      logic ss, clr;
      int   len;
      for (int seg = 0; seg < 200; seg++) begin
         ss  = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 3) == 0);
         len = $urandom_range(1, 2 * D + 3);
         for (int i = 0; i < len; i++) begin
            reset = ($urandom_range(0, 150) == 0);
            step(ss, clr);
            checks++;
            if (state !== m_state || stop !== (m_state != S_RUN) ||
                running !== (m_state == S_RUN) || clear !== m_clear) begin
               errors++;
               $display("FAIL random seg %0d state %b stop %b running %b clear %b want %b/%b/%b/%b",
                        seg, state, stop, running, clear, m_state, m_state != S_RUN, m_state == S_RUN, m_clear);
            end
         end
      end
      reset = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset          = 1'b1;
      btn_start_stop = 1'b0;
      btn_clear      = 1'b0;
      test_reset();
      test_bounce();
      test_hold_start();
      test_run_pause_clear();
      test_clear_running();
      test_simultaneous();
      test_reset_mid_debounce();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
